// File: rtl/max7219_if.sv
// max7219_if: serial lines from the display driver to the MAX7219 receiver model
interface max7219_if;
    logic cs_n;
    logic sclk;
    logic mosi;
    modport master (output cs_n, sclk, mosi);
    modport slave  (input  cs_n, sclk, mosi);
endinterface

// File: rtl/max7219_rx.sv
// max7219_rx: cycle-level MAX7219 receiver with register file and code-B readback
module max7219_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    max7219_if.slave    spi,
    input  logic [2:0]  rd_sel,
    output logic [7:0]  rd_seg,
    output logic [63:0] digits,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown_n,
    output logic        disp_test,
    output logic        frame_valid,
    output logic [3:0]  frame_addr,
    output logic [7:0]  frame_data,
    output logic        frame_err
);
    localparam logic [6:0] CODE_B [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00
    };
    logic [SYNC_STAGES-1:0] cs_s, sck_s, mo_s;
    logic                   cs_d, sck_d, armed;
    logic [11:0]            sr;
    logic [CNT_W-1:0]       cnt;
    logic                   cs_now, cs_fall, cs_rise, sck_rise, long_enough;
    logic [7:0]             cur;
    assign cs_now      = cs_s[SYNC_STAGES-1];
    assign cs_fall     = ~cs_now & cs_d;
    // armed blocks a frame that was in flight across reset from being used
    assign cs_rise     = cs_now & ~cs_d & armed;
    assign sck_rise    = sck_s[SYNC_STAGES-1] & ~sck_d & ~cs_now & armed;
    assign long_enough = 32'(cnt) >= 32'd16;
    always_comb begin
        cur    = digits[{rd_sel, 3'b000} +: 8];
        rd_seg = disp_test ? 8'hFF : decode_mode[rd_sel] ? {cur[7], CODE_B[cur[3:0]]} : cur;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_s  <= '0;
            sck_s <= '0;
            mo_s  <= '0;
            cs_d  <= 1'b0;
            sck_d <= 1'b0;
            armed <= 1'b0;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            cs_s  <= {cs_s[SYNC_STAGES-2:0], spi.cs_n};
            sck_s <= {sck_s[SYNC_STAGES-2:0], spi.sclk};
            mo_s  <= {mo_s[SYNC_STAGES-2:0], spi.mosi};
            cs_d  <= cs_now;
            sck_d <= sck_s[SYNC_STAGES-1];
            armed <= cs_fall ? 1'b1 : cs_rise ? 1'b0 : armed;
            sr    <= sck_rise ? {sr[10:0], mo_s[SYNC_STAGES-1]} : sr;
            cnt   <= cs_fall ? '0 : (sck_rise && cnt != '1) ? cnt + 1'b1 : cnt;
        end
    end
    // D15..D12 never reach the registers, so only the low 12 bits are kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            decode_mode <= '0;
            intensity   <= '0;
            scan_limit  <= '0;
            shutdown_n  <= 1'b0;
            disp_test   <= 1'b0;
            frame_valid <= 1'b0;
            frame_addr  <= '0;
            frame_data  <= '0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= cs_rise & long_enough;
            frame_err   <= cs_rise & ~long_enough;
            if (cs_rise && long_enough) begin
                frame_addr <= sr[11:8];
                frame_data <= sr[7:0];
                if (sr[11:8] >= 4'h1 && sr[11:8] <= 4'h8)
                    digits[{sr[10:8] - 3'd1, 3'b000} +: 8] <= sr[7:0];
                if (sr[11:8] == 4'h9) decode_mode <= sr[7:0];
                if (sr[11:8] == 4'hA) intensity <= sr[3:0];
                if (sr[11:8] == 4'hB) scan_limit <= sr[2:0];
                if (sr[11:8] == 4'hC) shutdown_n <= sr[0];
                if (sr[11:8] == 4'hF) disp_test <= sr[0];
            end
        end
    end
endmodule

// File: tb/tb_max7219_rx.sv
// tb_max7219_rx: randomized and directed frames checked against a register-level model
module tb_max7219_rx;
    localparam int SS = 2;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_sel;
    logic [7:0]  rd_seg;
    logic [63:0] digits;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n, disp_test, frame_valid, frame_err;
    logic [3:0]  frame_addr;
    logic [7:0]  frame_data;
    max7219_if bus();
    max7219_rx #(.SYNC_STAGES(SS), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .spi(bus), .rd_sel(rd_sel), .rd_seg(rd_seg),
        .digits(digits), .decode_mode(decode_mode), .intensity(intensity),
        .scan_limit(scan_limit), .shutdown_n(shutdown_n), .disp_test(disp_test),
        .frame_valid(frame_valid), .frame_addr(frame_addr), .frame_data(frame_data),
        .frame_err(frame_err)
    );
    always #10 clk = ~clk;
    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] m_dig [8];
    logic [7:0] m_dec, m_data;
    logic [3:0] m_int, m_addr;
    logic [2:0] m_scan;
    logic       m_shdn, m_test;
    logic [6:0] cb [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00};
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask
    function automatic void model_reset();
        for (int k = 0; k < 8; k++) m_dig[k] = 8'h00;
        m_dec = 0; m_data = 0; m_int = 0; m_addr = 0; m_scan = 0; m_shdn = 0; m_test = 0;
    endfunction
    function automatic void apply(input logic [15:0] w);
        int a;
        a = int'(w[11:8]);
        m_addr = w[11:8];
        m_data = w[7:0];
        if (a >= 1 && a <= 8) m_dig[a-1] = w[7:0];
        if (a == 9)  m_dec  = w[7:0];
        if (a == 10) m_int  = w[3:0];
        if (a == 11) m_scan = w[2:0];
        if (a == 12) m_shdn = w[0];
        if (a == 15) m_test = w[0];
    endfunction
    function automatic logic [7:0] exp_seg(input int k);
        if (m_test) return 8'hFF;
        if (m_dec[k]) return {m_dig[k][7], cb[m_dig[k][3:0]]};
        return m_dig[k];
    endfunction
    task automatic check_regs();
        logic [63:0] f;
        for (int k = 0; k < 8; k++) f[8*k +: 8] = m_dig[k];
        check("digits", digits, f);
        check("decode_mode", decode_mode, m_dec);
        check("intensity", intensity, m_int);
        check("scan_limit", scan_limit, m_scan);
        check("shutdown_n", shutdown_n, m_shdn);
        check("disp_test", disp_test, m_test);
        check("frame_addr", frame_addr, m_addr);
        check("frame_data", frame_data, m_data);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk) rd_sel = 3'(k);
            #1 check("rd_seg", rd_seg, exp_seg(k));
        end
    endtask
    task automatic seg0(input logic [7:0] exp);
        @(negedge clk) rd_sel = 3'd0;
        #1 check("seg0", rd_seg, exp);
    endtask
    task automatic clock_bit(input logic b);
        bus.mosi = b;
        repeat (2) @(negedge clk);
        bus.sclk = 1'b1;
        repeat (2) @(negedge clk);
        bus.sclk = 1'b0;
    endtask
    task automatic send(input logic [31:0] w, input int n);
        int lat;
        logic gv, ge;
        lat = 0; gv = 0; ge = 0;
        @(negedge clk) bus.cs_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) clock_bit(w[i]);
        repeat (2) @(negedge clk);
        bus.cs_n = 1'b1;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid || frame_err) begin
                lat = k; gv = frame_valid; ge = frame_err;
            end
        end
        check("latency", lat, SS + 1);
        check("valid", gv, n >= 16);
        check("err", ge, n < 16);
        @(posedge clk);
        #1 check("pulse_len", {frame_valid, frame_err}, 0);
        if (n >= 16) apply(w[15:0]);
        check_regs();
    endtask
    initial begin
        int pulses, n;
        rst = 1'b1; rd_sel = 0;
        bus.cs_n = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (100) begin
            @(posedge clk);
            #1 if (frame_valid || frame_err) pulses++;
        end
        check("idle_pulses", pulses, 0);
        check_regs();
        seg0(8'h00);
        send(32'h0C01, 16);
        check("shutdown_on", shutdown_n, 1'b1);
        send(32'h09FF, 16);
        send(32'h0105, 16);
        seg0(8'h5B);
        send(32'h0185, 16);
        seg0(8'hDB);
        send(32'h0900, 16);
        seg0(8'h85);
        send(32'h0A07, 12);
        check("intensity_after_err", intensity, 4'h0);
        send(32'hAA0A07, 24);
        check("intensity_long", intensity, 4'h7);
        check("addr_long", frame_addr, 4'hA);
        send(32'h0F01, 16);
        seg0(8'hFF);
        send(32'h0F00, 16);
        seg0(8'h85);
        for (int t = 0; t < 24; t++) begin
            n = ($urandom_range(0, 3) == 0) ?
                (($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(17, 32))) : 16;
            send($urandom, n);
        end
        @(negedge clk) bus.cs_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 15; i >= 8; i--) clock_bit(1'(16'h0B05 >> i));
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        bus.cs_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (frame_valid || frame_err) pulses++;
        end
        check("reset_discard", pulses, 0);
        send(32'h0B03, 16);
        check("scan_after_reset", scan_limit, 3'd3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/max7219_rx.md
Name: max7219_rx

Overview:
- Cycle-level receiver model of the MAX7219 serial interface, running on the system clock.
- Samples the cs_n/sclk/mosi lines driven by the display-driver side of the stopwatch and decodes each 16-bit frame.
- Holds the resulting digit and control registers and gives a readback port with code-B decoding, so benches and on-board LED mirrors can check what the display would show.
- The sampled lines are asynchronous to clk and are synchronized internally.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizers on cs_n, sclk and mosi (minimum 2).
CNT_W, 6, width of the bit counter. The counter saturates at 2^CNT_W-1.

Ports:
clk  input  1  system clock, 50 MHz. sclk must stay at or below clk/4.
rst  input  1  asynchronous active-high reset.
cs_n  input  1  chip select, active low. Its rising edge latches the frame.
sclk  input  1  serial clock. mosi is sampled on its rising edge.
mosi  input  1  serial data, MSB first.
rd_sel  input  3  digit index for readback, 0..7.
rd_seg  output  8  segment pattern of the selected digit, format {DP,A,B,C,D,E,F,G}.
digits  output  64  raw digit registers; digit k occupies bits [8k+7:8k].
decode_mode  output  8  per-digit code-B enable.
intensity  output  4  brightness register.
scan_limit  output  3  scan-limit register.
shutdown_n  output  1  1 = normal operation, 0 = shutdown.
disp_test  output  1  display-test register.
frame_valid  output  1  one-cycle pulse when a frame is latched.
frame_addr  output  4  address nibble (D11..D8) of the last latched frame.
frame_data  output  8  data byte (D7..D0) of the last latched frame.
frame_err  output  1  one-cycle pulse when cs_n rises after fewer than 16 bits.

Behaviour:
- Reset: all outputs and registers go to 0 (shutdown_n=0, digits=0, decode_mode=0, intensity=0, scan_limit=0, disp_test=0, no pulses). The synchronizers, shift register and bit counter are also cleared.
- Inputs pass through SYNC_STAGES flops. Edges are detected by comparing the last synced value with one extra registered copy.
- cs_n falling edge: bit counter cleared. The shift register is not cleared.
- sclk rising edge while synced cs_n=0: shift register becomes {sr[14:0], mosi_sync}. The bit counter increments and saturates.
- sclk edges while cs_n=1 are ignored. mosi is sampled only at detected sclk rises.
- cs_n rising edge:
  - Count >= 16: latch sr[15:0]. This means the last 16 bits received, which supports cascaded and over-long frames.
  - Count < 16: assert frame_err for one cycle. No register changes.
- Latch timing: registers, frame_addr, frame_data and the frame_valid pulse all update in the cycle the synced rise is detected. This is SYNC_STAGES+1 clk cycles after the cs_n pin rises.
- Address decode, with D15..D12 ignored:
  - 0x0: no-op. frame_valid still pulses.
  - 0x1..0x8: digits[addr-1] <= D7..D0.
  - 0x9: decode_mode <= D7..D0.
  - 0xA: intensity <= D3..D0.
  - 0xB: scan_limit <= D2..D0.
  - 0xC: shutdown_n <= D0.
  - 0xF: disp_test <= D0.
  - 0xD, 0xE: no register change. frame_valid still pulses.
- rd_seg is combinational from registers, with priority in this order:
  - disp_test=1: 0xFF.
  - decode_mode[rd_sel]=1: {D7 as DP, codeB(D3..D0)}; D6..D4 ignored. codeB table:
    - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
    - 8=7F, 9=7B, A('-')=01, B(E)=4F, C(H)=37, D(L)=0E, E(P)=67, F(blank)=00
  - Otherwise: the raw digit register.
- shutdown_n and scan_limit do not mask rd_seg; they are reported only.
- A cs_n rise and an sclk rise detected in the same cycle: the sclk bit is ignored and the latch uses the shift register as it stood.
- Reset asserted mid-frame: the partial frame is discarded. After release, bits are accepted only after a new cs_n falling edge.

Test Plan:
- Reset, then release with cs_n=1 -> all outputs 0, rd_seg=0x00, no pulses for 100 cycles.
- Frame 0x0C01 at sclk=clk/4 -> frame_valid one cycle, frame_addr=0xC, frame_data=0x01, shutdown_n=1, latency SYNC_STAGES+1 cycles from the cs_n rise.
- Frames 0x09FF then 0x0105, rd_sel=0 -> rd_seg=0x5B. Then 0x0185 -> rd_seg=0xDB. Then 0x0900, rd_sel=0 -> rd_seg=0x85 (raw).
- 12-bit frame 0xA07, then cs_n high -> frame_err pulse, no frame_valid, intensity stays 0.
- 24-bit frame 0xAA0A07 -> intensity=7, frame_addr=0xA. Then 0x0F01 -> rd_seg=0xFF for every rd_sel. Then 0x0F00 -> normal readback.
- Assert rst after 8 bits of 0x0B05, then release and send 0x0B03 -> scan_limit=3 and exactly one frame_valid pulse.
